// File: rtl/game_pkg.sv
// game_pkg: shared screen geometry, LFSR taps, motion modes and spawn helper.
package game_pkg;
    localparam int COORD_W = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int LFSR_TAP_A = 9;
    localparam int LFSR_TAP_B = 6;
    localparam logic MODE_DIAG = 1'b0;
    localparam logic MODE_LEFT = 1'b1;
    typedef enum logic {ALIVE, DEAD} enemy_state_e;
    function automatic logic [COORD_W-1:0] wrap_spawn(input logic [COORD_W-1:0] v, input int base, input int span);
        return COORD_W'(base + int'(v) % span);
    endfunction
endpackage

// File: rtl/enemy_swarm_move_if.sv
// enemy_swarm_move_if: control inputs from game logic and per-enemy sprite outputs.
interface enemy_swarm_move_if import game_pkg::*; #(parameter int N_ENEMY = 4);
    logic pause;
    logic mode;
    logic [COORD_W-1:0] seed;
    logic [N_ENEMY-1:0] hit;
    logic [COORD_W*N_ENEMY-1:0] pos_x;
    logic [COORD_W*N_ENEMY-1:0] pos_y;
    logic [N_ENEMY-1:0] show_valid;
    logic [N_ENEMY-1:0] kill_pulse;
    logic [3:0] alive_cnt;
    modport master(output pause, mode, seed, hit, input pos_x, pos_y, show_valid, kill_pulse, alive_cnt);
    modport slave(input pause, mode, seed, hit, output pos_x, pos_y, show_valid, kill_pulse, alive_cnt);
endinterface

// File: rtl/lfsr10.sv
// lfsr10: 10-bit Fibonacci LFSR, x^10+x^7+1, loaded from seed on reset.
module lfsr10 import game_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic [COORD_W-1:0] seed,
    output logic [COORD_W-1:0] num
);
    always_ff @(posedge clk) begin
        if (rst) num <= seed;
        else if (en) num <= {num[COORD_W-2:0], num[LFSR_TAP_A] ^ num[LFSR_TAP_B]};
    end
endmodule

// File: rtl/enemy_swarm_move.sv
// enemy_swarm_move: N independent leftward-moving enemies with edge/hit kill,
// cooldown and pseudo-random respawn.
module enemy_swarm_move import game_pkg::*; #(
    parameter int N_ENEMY  = 4,
    parameter int STEP     = 5,
    parameter int CD_TICKS = 100,
    parameter int EDGE     = 3,
    parameter int X_MAX    = SCREEN_W,
    parameter int Y_MAX    = SCREEN_H,
    parameter int SPAWN_X0 = 430,
    parameter int SPAWN_XW = 200,
    parameter int SPAWN_Y0 = 40,
    parameter int SPAWN_YH = 430
) (
    input logic clk_22,
    input logic rst,
    enemy_swarm_move_if.slave bus
);
    localparam int CD_W = (CD_TICKS >= 128) ? $clog2(CD_TICKS + 1) : 7;
    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] EDGE_C = COORD_W'(EDGE);
    localparam logic [COORD_W-1:0] XMAX_C = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(Y_MAX);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(CD_TICKS);
    logic [COORD_W*N_ENEMY-1:0] px, py;
    logic [N_ENEMY-1:0] sv, kpv, alive_nxt;
    logic [3:0] cnt, cnt_r;
    genvar g;
    generate
        for (g = 0; g < N_ENEMY; g++) begin : ch
            logic [COORD_W-1:0] s, r, num, rot, x, y;
            logic [CD_W-1:0] cd;
            enemy_state_e st;
            logic kp, off;
            assign s = bus.seed ^ COORD_W'(g * 'h089);
            assign r = (s == '0) ? COORD_W'(1) : s;
            assign rot = {num[4:0], num[9:5]};
            // underflowed coordinates wrap high and are caught by the max tests
            assign off = x < EDGE_C || x >= XMAX_C || y < EDGE_C || y >= YMAX_C;
            lfsr10 u_lfsr (.clk(clk_22), .rst(rst), .en(!bus.pause), .seed(r), .num(num));
            always_ff @(posedge clk_22) begin
                if (rst) begin
                    st <= ALIVE;
                    cd <= '0;
                    kp <= 1'b0;
                    x  <= wrap_spawn(r, SPAWN_X0, SPAWN_XW);
                    y  <= wrap_spawn(r, SPAWN_Y0, SPAWN_YH);
                end else if (!bus.pause) begin
                    kp <= 1'b0;
                    if (st == DEAD) begin
                        cd <= (cd == CD_LAST) ? '0 : cd + CD_W'(1);
                        if (cd == CD_LAST) begin
                            st <= ALIVE;
                            x  <= wrap_spawn(num, SPAWN_X0, SPAWN_XW);
                            y  <= wrap_spawn(rot, SPAWN_Y0, SPAWN_YH);
                        end
                    end else if (off) begin
                        st <= DEAD;
                        cd <= '0;
                    end else if (bus.hit[g]) begin
                        st <= DEAD;
                        cd <= '0;
                        kp <= 1'b1;
                    end else begin
                        x <= x - STEP_C;
                        y <= (bus.mode == MODE_LEFT) ? y : num[0] ? y + STEP_C : y - STEP_C;
                    end
                end
            end
            assign alive_nxt[g] = bus.pause ? (st == ALIVE) : (st == DEAD) ? (cd == CD_LAST) : !(off || bus.hit[g]);
            assign px[COORD_W*g +: COORD_W] = x;
            assign py[COORD_W*g +: COORD_W] = y;
            assign sv[g] = (st == ALIVE);
            assign kpv[g] = kp;
        end
    endgenerate
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_ENEMY; i++) cnt = cnt + {3'b000, alive_nxt[i]};
    end
    always_ff @(posedge clk_22) cnt_r <= rst ? 4'(N_ENEMY) : cnt;
    assign bus.pos_x = px;
    assign bus.pos_y = py;
    assign bus.show_valid = sv;
    assign bus.kill_pulse = kpv;
    assign bus.alive_cnt = cnt_r;
endmodule

// File: doc/enemy_swarm_move.md
# enemy_swarm_move

Parametrised multi-channel enemy mover and the successor of the single-dragon mover. It drives `N_ENEMY` independent enemies that step leftward each `clk_22` tick in one of two selectable motion modes. Each enemy dies on hitting a screen edge or on an external hit, then respawns at a pseudo-random position after a configurable cooldown. It sits between the collision/memory logic (source of `hit`) and the VGA sprite renderer (consumer of the positions and `show_valid`).

## Interface
- `N_ENEMY`, 4: number of enemy channels (1..8).
- `STEP`, 5: pixels moved per axis per tick.
- `CD_TICKS`, 100: dead-time ticks before respawn.
- `EDGE`, 3: x/y strictly below this value count as off-screen.
- `X_MAX`, 640; `Y_MAX`, 480: x/y at or above these values count as off-screen.
- `SPAWN_X0`, 430; `SPAWN_XW`, 200: respawn x = `SPAWN_X0` + (rnd mod `SPAWN_XW`).
- `SPAWN_Y0`, 40; `SPAWN_YH`, 430: respawn y = `SPAWN_Y0` + (rnd mod `SPAWN_YH`).
- `clk_22` in 1: game tick clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pause` in 1: freezes all state while high.
- `mode` in 1: 0 = random diagonal, 1 = straight left.
- `seed` in 10: random seed, sampled only during reset.
- `hit` in `N_ENEMY`: per-channel kill request, level-sampled each tick.
- `pos_x`, `pos_y` out `10*N_ENEMY`: top-left pixel of each enemy; channel i occupies bits [10i+9:10i].
- `show_valid` out `N_ENEMY`: 1 = enemy alive and drawn.
- `kill_pulse` out `N_ENEMY`: one-tick pulse when a `hit` kill is taken (score credit).
- `alive_cnt` out 4: number of channels currently alive.

## Operation
- Per-channel state machine with two states plus a cooldown counter `cd` (7 bits min, sized to `CD_TICKS`):
  - ALIVE: moves each tick.
  - DEAD: `cd` increments each tick. When `cd == CD_TICKS`, the channel loads the respawn position, returns to ALIVE and clears `cd`.
- Per-channel priority each tick, highest first:
  1. `rst`
  2. `pause` (hold everything)
  3. DEAD handling
  4. Edge kill: `x<EDGE || x>=X_MAX || y<EDGE || y>=Y_MAX`, evaluated on the current registered position.
  5. Hit kill
  6. Move
- Edge kill and hit kill both enter DEAD with `cd=0` and leave the position unchanged. Only a hit kill asserts `kill_pulse`. If an edge kill and `hit` occur on the same tick, it counts as an edge kill with no pulse.
- `hit` while DEAD or paused is ignored.
- Move:
  - `mode=0`: x -= `STEP`; y += `STEP` if the channel's LFSR bit0 = 1, else y -= `STEP`.
  - `mode=1`: x -= `STEP`; y held.
  - `mode` is sampled every tick, so a change takes effect on the next move.
- Arithmetic: 10-bit unsigned, modulo 1024. An underflow (e.g. x=3, `STEP`=5 giving 1022) is caught by the `>=X_MAX` test on the following tick.
- Random source: one 10-bit Fibonacci LFSR per channel, polynomial x^10+x^7+1.
  - Seeded at reset with `seed ^ (i*10'h089)`. A zero seed is replaced by 10'h001.
  - Advances every non-paused tick.
  - Respawn uses the LFSR value for x and the value rotated left 5 bits for y.
- Reset values per channel i, with r = effective seed: `pos_x = SPAWN_X0 + r mod SPAWN_XW`, `pos_y = SPAWN_Y0 + r mod SPAWN_YH`, ALIVE, `cd=0`, `kill_pulse=0`. `alive_cnt = N_ENEMY`.
- `rst` asserted mid-cooldown or mid-move overrides all other inputs on that edge.

## Timing
- All outputs are registered and update on the `clk_22` rising edge.
- `hit` sampled at edge k gives `show_valid=0` and `kill_pulse=1` after edge k. `kill_pulse` returns to 0 after edge k+1.
- Dead duration: kill at edge k, respawn at edge k+`CD_TICKS`+1, so `show_valid` is low for `CD_TICKS`+1 ticks.
- While `pause` is high, all registers hold, including the LFSRs, `cd` and `kill_pulse`. Resuming continues exactly where the block stopped.
- `alive_cnt` is a registered popcount of next-state alive flags, so it is coherent with `show_valid`.

## Structure
- Shared package `game_pkg`: `COORD_W=10`, `SCREEN_W=640`, `SCREEN_H=480`, LFSR polynomial taps, `MODE_DIAG`/`MODE_LEFT` constants.
- Sub-module `lfsr10`: ports clk, rst, en, seed, num. Instantiated `N_ENEMY` times in a generate loop, as is the per-channel FSM.

## Test plan
- Reset with `seed=10'h000`, `N_ENEMY=4`: channel 0 uses r=1, giving `pos=(431,41)`. All `show_valid=1111` and `alive_cnt=4`.
- `mode=1`, channel 0 at x=438: after 1 tick x=433 with y unchanged. Continue to x=3, then to 1022, then DEAD with no `kill_pulse`.
- `hit[2]=1` for 1 tick: `show_valid[2]=0` and `kill_pulse[2]=1` for exactly 1 tick. Respawn 101 ticks later at a position with x in [430,629] and y in [40,469].
- `pause` high 20 ticks during cooldown at `cd=50`: outputs and LFSR are frozen. Respawn still occurs after a total of 101 unpaused ticks.
- `hit[1]` on the same tick channel 1 is at x=2: edge-kill path taken with no `kill_pulse`. `hit` held high while DEAD has no effect.
- `rst` pulsed at `cd=60`: next tick the channel is ALIVE at its reset position and `alive_cnt=4`.
